// File: rtl/eq_mix_engine.sv
// eq_mix_engine: per-channel multi-band EQ mix with master volume.
// Each frame is snapshotted and then processed serially through one shared
// multiplier: NUM_BANDS MAC cycles plus one volume cycle per channel, then a
// single DONE cycle that publishes all channels at once.
module eq_mix_engine #(
    parameter int NUM_BANDS = 5,
    parameter int NUM_CH    = 2,
    parameter int SMPL_W    = 16,
    parameter int POT_W     = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            smpl_vld,
    input  logic [NUM_CH*NUM_BANDS*SMPL_W-1:0] bands_in,
    input  logic [NUM_BANDS*POT_W-1:0]      band_pots,
    input  logic [POT_W-1:0]                vol_pot,
    input  logic                            clr_flags,
    output logic [NUM_CH*SMPL_W-1:0]        mix_out,
    output logic                            out_vld,
    output logic                            busy,
    output logic                            sat_flag,
    output logic                            ovr_flag
);

    // Product of a signed sample and a zero-extended pot.
    localparam int PROD_W = SMPL_W + POT_W + 1;
    // Each band term is PROD_W-10 bits; summing NUM_BANDS of them needs clog2 more.
    localparam int ACC_W  = PROD_W - 10 + $clog2(NUM_BANDS);
    localparam int BIDX_W = $clog2(NUM_BANDS);
    localparam int CIDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NSMP   = NUM_CH * NUM_BANDS;
    localparam int SEL_W  = $clog2(NSMP);

    localparam logic signed [PROD_W-1:0] SMAX = PROD_W'((2 ** (SMPL_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, VOL, DONE} state_t;

    // Clamp to the sample range; the top bit reports whether clamping happened.
    function automatic logic [SMPL_W:0] sat16(input logic signed [PROD_W-1:0] x);
        if (x > SMAX) begin
            return {1'b1, SMAX[SMPL_W-1:0]};
        end else if (x < SMIN) begin
            return {1'b1, SMIN[SMPL_W-1:0]};
        end
        return {1'b0, x[SMPL_W-1:0]};
    endfunction

    state_t                     state_q, state_d;
    logic [CIDX_W-1:0]          ch_q, ch_d;
    logic [BIDX_W-1:0]          band_q, band_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SMPL_W-1:0]   smpl_q [NSMP];
    logic signed [SMPL_W-1:0]   smpl_d [NSMP];
    logic [POT_W-1:0]           pot_q [NUM_BANDS];
    logic [POT_W-1:0]           pot_d [NUM_BANDS];
    logic [POT_W-1:0]           vol_q, vol_d;
    logic signed [SMPL_W-1:0]   res_q [NUM_CH];
    logic signed [SMPL_W-1:0]   res_d [NUM_CH];
    logic [NUM_CH*SMPL_W-1:0]   mix_q, mix_d;
    logic                       out_vld_q, out_vld_d;
    logic                       sat_q, sat_d;
    logic                       ovr_q, ovr_d;

    logic [SEL_W-1:0]           sel;
    logic signed [SMPL_W-1:0]   mul_a;
    logic signed [POT_W:0]      mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   prod_sh10;
    logic signed [ACC_W-1:0]    mac_term;
    logic [SMPL_W:0]            acc_s;
    logic [SMPL_W:0]            vol_s;

    // Shared multiplier: band sample x band pot in MAC, saturated acc x volume in VOL.
    always_comb begin
        sel       = SEL_W'(32'(ch_q) * NUM_BANDS + 32'(band_q));
        acc_s     = sat16(PROD_W'(acc_q));
        mul_a     = smpl_q[sel];
        mul_b     = {1'b0, pot_q[band_q]};
        if (state_q == VOL) begin
            mul_a = acc_s[SMPL_W-1:0];
            mul_b = {1'b0, vol_q};
        end
        prod      = PROD_W'(mul_a) * PROD_W'(mul_b);
        prod_sh10 = prod >>> 10;
        mac_term  = ACC_W'(prod_sh10);
        vol_s     = sat16(prod >>> 11);
    end

    // Next-state, datapath updates and sticky flag logic.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        band_d    = band_q;
        acc_d     = acc_q;
        smpl_d    = smpl_q;
        pot_d     = pot_q;
        vol_d     = vol_q;
        res_d     = res_q;
        mix_d     = mix_q;
        out_vld_d = 1'b0;
        sat_d     = sat_q;
        ovr_d     = ovr_q;

        // Clear first so that a same-cycle set event below wins.
        if (clr_flags) begin
            sat_d = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (smpl_vld) begin
                    for (int i = 0; i < NSMP; i++) begin
                        smpl_d[i] = bands_in[i*SMPL_W +: SMPL_W];
                    end
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        pot_d[b] = band_pots[b*POT_W +: POT_W];
                    end
                    vol_d   = vol_pot;
                    ch_d    = '0;
                    band_d  = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + mac_term;
                if (band_q == BIDX_W'(NUM_BANDS - 1)) begin
                    state_d = VOL;
                end else begin
                    band_d = band_q + BIDX_W'(1);
                end
            end
            VOL: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (CIDX_W'(c) == ch_q) begin
                        res_d[c] = vol_s[SMPL_W-1:0];
                    end
                end
                if (acc_s[SMPL_W] || vol_s[SMPL_W]) begin
                    sat_d = 1'b1;
                end
                if (ch_q == CIDX_W'(NUM_CH - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + CIDX_W'(1);
                    band_d  = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            DONE: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    mix_d[c*SMPL_W +: SMPL_W] = res_q[c];
                end
                out_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe outside IDLE is dropped and only recorded.
        if (smpl_vld && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            band_q    <= '0;
            acc_q     <= '0;
            vol_q     <= '0;
            mix_q     <= '0;
            out_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            ovr_q     <= 1'b0;
            for (int i = 0; i < NSMP; i++) begin
                smpl_q[i] <= '0;
            end
            for (int b = 0; b < NUM_BANDS; b++) begin
                pot_q[b] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                res_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            band_q    <= band_d;
            acc_q     <= acc_d;
            smpl_q    <= smpl_d;
            pot_q     <= pot_d;
            vol_q     <= vol_d;
            res_q     <= res_d;
            mix_q     <= mix_d;
            out_vld_q <= out_vld_d;
            sat_q     <= sat_d;
            ovr_q     <= ovr_d;
        end
    end

    assign mix_out  = mix_q;
    assign out_vld  = out_vld_q;
    assign busy     = (state_q != IDLE);
    assign sat_flag = sat_q;
    assign ovr_flag = ovr_q;

endmodule

// File: tb/tb_eq_mix_engine.sv
// Testbench for eq_mix_engine: scoreboard of expected frames produced by an
// integer reference model, checked when out_vld fires.
module tb_eq_mix_engine;

    localparam int NB = 5;
    localparam int NC = 2;
    localparam int SW = 16;
    localparam int PW = 12;
    localparam int NB2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   smpl_vld;
    logic [NC*NB*SW-1:0]    bands_in;
    logic [NB*PW-1:0]       band_pots;
    logic [PW-1:0]          vol_pot;
    logic                   clr_flags;
    logic [NC*SW-1:0]       mix_out;
    logic                   out_vld, busy, sat_flag, ovr_flag;

    logic                   s_smpl_vld;
    logic [NB2*SW-1:0]      s_bands;
    logic [NB2*PW-1:0]      s_pots;
    logic [PW-1:0]          s_vol;
    logic                   s_clr;
    logic [SW-1:0]          s_mix;
    logic                   s_vld, s_busy, s_sat, s_ovr;

    eq_mix_engine #(.NUM_BANDS(NB), .NUM_CH(NC), .SMPL_W(SW), .POT_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld), .bands_in(bands_in),
        .band_pots(band_pots), .vol_pot(vol_pot), .clr_flags(clr_flags),
        .mix_out(mix_out), .out_vld(out_vld), .busy(busy),
        .sat_flag(sat_flag), .ovr_flag(ovr_flag)
    );

    eq_mix_engine #(.NUM_BANDS(NB2), .NUM_CH(1), .SMPL_W(SW), .POT_W(PW)) dut_small (
        .clk(clk), .rst_n(rst_n), .smpl_vld(s_smpl_vld), .bands_in(s_bands),
        .band_pots(s_pots), .vol_pot(s_vol), .clr_flags(s_clr),
        .mix_out(s_mix), .out_vld(s_vld), .busy(s_busy),
        .sat_flag(s_sat), .ovr_flag(s_ovr)
    );

    typedef struct {
        logic [NC*SW-1:0] mix;
        bit               sat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vld_cnt = 0;

    int smp [4][8];
    int pot [8];
    int vol_i;

    always @(negedge clk) if (out_vld === 1'b1) vld_cnt++;

    function automatic longint fdiv(input longint x, input longint d);
        longint q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint clampv(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model(input int nc, input int nb, output logic [63:0] mixv, output bit sat);
        longint acc, s, v0, v;
        mixv = '0;
        sat  = 1'b0;
        for (int c = 0; c < nc; c++) begin
            acc = 0;
            for (int b = 0; b < nb; b++) acc += fdiv(longint'(smp[c][b]) * pot[b], 1024);
            s = clampv(acc);
            if (s != acc) sat = 1'b1;
            v0 = fdiv(s * vol_i, 2048);
            v = clampv(v0);
            if (v != v0) sat = 1'b1;
            mixv[c*16 +: 16] = v[15:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs the stimulus arrays onto the DUT inputs, pushes the expected result
    // and strobes smpl_vld so it is sampled at "edge 0".
    task automatic drive_frame();
        logic [63:0] m;
        bit s;
        exp_t e;
        for (int c = 0; c < NC; c++)
            for (int b = 0; b < NB; b++) bands_in[(c*NB+b)*SW +: SW] = 16'(smp[c][b]);
        for (int b = 0; b < NB; b++) band_pots[b*PW +: PW] = 12'(pot[b]);
        vol_pot = 12'(vol_i);
        model(NC, NB, m, s);
        e.mix = m[NC*SW-1:0];
        e.sat = s;
        exp_q.push_back(e);
        clr_flags = 1'b1;
        smpl_vld = 1'b1;
        tick();
        smpl_vld = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (out_vld !== 1'b1 && lat < 60);
    endtask

    task automatic fill(input int sv0, input int sv1, input int pv, input int vv);
        for (int b = 0; b < 8; b++) begin
            smp[0][b] = sv0;
            smp[1][b] = sv1;
            pot[b] = pv;
        end
        vol_i = vv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; smpl_vld = 1'b0; clr_flags = 1'b0;
        bands_in = '0; band_pots = '0; vol_pot = '0;
        s_smpl_vld = 1'b0; s_clr = 1'b0; s_bands = '0; s_pots = '0; s_vol = '0;
        repeat (3) tick();
        checks++;
        if ({mix_out, out_vld, busy, sat_flag, ovr_flag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got mix=%h vld=%b busy=%b sat=%b ovr=%b want all 0",
                     mix_out, out_vld, busy, sat_flag, ovr_flag);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({s_mix, s_vld, s_busy} !== '0) begin
            errors++;
            $display("FAIL reset_small: got mix=%h vld=%b busy=%b want 0", s_mix, s_vld, s_busy);
        end
    endtask

    task automatic test_unity();
        int lat;
        exp_t e;
        logic [NC*SW-1:0] held;
        fill(100, -100, 'h400, 'h800);
        drive_frame();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL unity_busy: got %b want 1", busy);
        end
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL unity_latency: got %0d want 13", lat);
        end
        checks++;
        if (mix_out !== e.mix || mix_out !== {16'hFE0C, 16'h01F4}) begin
            errors++;
            $display("FAIL unity_mix: got %h want %h", mix_out, e.mix);
        end
        checks++;
        if ({sat_flag, ovr_flag, busy} !== 3'b000) begin
            errors++;
            $display("FAIL unity_flags: got sat=%b ovr=%b busy=%b want 0", sat_flag, ovr_flag, busy);
        end
        held = mix_out;
        tick();
        checks++;
        if (out_vld !== 1'b0 || mix_out !== held) begin
            errors++;
            $display("FAIL unity_hold: got vld=%b mix=%h want vld=0 mix=%h", out_vld, mix_out, held);
        end
    endtask

    task automatic test_saturation();
        int lat;
        exp_t e;
        fill(32767, 32767, 'hFFF, 'h800);
        drive_frame();
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (mix_out !== e.mix || mix_out[15:0] !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos_mix: got %h want %h", mix_out, e.mix);
        end
        checks++;
        if (sat_flag !== 1'b1 || e.sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_flag: got %b want 1", sat_flag);
        end
        fill(-32768, -32768, 'hFFF, 'h800);
        drive_frame();
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (mix_out !== e.mix || mix_out !== 32'h80008000) begin
            errors++;
            $display("FAIL sat_neg_mix: got %h want %h", mix_out, e.mix);
        end
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_floor();
        int lat;
        exp_t e;
        fill(1234, -777, 0, 'h800);
        smp[0][0] = -3;
        smp[1][0] = -3;
        pot[0] = 'h200;
        drive_frame();
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (mix_out !== e.mix || mix_out !== 32'hFFFEFFFE) begin
            errors++;
            $display("FAIL floor_neg: got %h want %h", mix_out, e.mix);
        end
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL floor_sat: got %b want 0", sat_flag);
        end
        fill(200, -200, 'h400, 'h400);
        drive_frame();
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (mix_out !== e.mix || mix_out[15:0] !== 16'd500) begin
            errors++;
            $display("FAIL half_vol: got %h want %h", mix_out, e.mix);
        end
    endtask

    task automatic test_snapshot();
        int lat;
        exp_t e;
        fill(321, -4000, 'h3A0, 'h6F0);
        smp[0][2] = 9000;
        pot[3] = 'h7FF;
        drive_frame();
        repeat (2) tick();
        band_pots = {NB{12'hFFF}};
        vol_pot = 12'h123;
        bands_in = {NC*NB{16'h1111}};
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL snapshot_latency: got %0d want 11", lat);
        end
        checks++;
        if (mix_out !== e.mix) begin
            errors++;
            $display("FAIL snapshot_mix: got %h want %h", mix_out, e.mix);
        end
    endtask

    task automatic test_overrun();
        int lat, start;
        exp_t e;
        fill(-1500, 2500, 'h500, 'h700);
        drive_frame();
        start = vld_cnt;
        checks++;
        if (ovr_flag !== 1'b0) begin
            errors++;
            $display("FAIL ovr_before: got %b want 0", ovr_flag);
        end
        repeat (4) tick();
        bands_in = {NC*NB{16'h2222}};
        band_pots = {NB{12'h800}};
        smpl_vld = 1'b1;
        clr_flags = 1'b1;
        tick();
        smpl_vld = 1'b0;
        clr_flags = 1'b0;
        checks++;
        if (ovr_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set_priority: got %b want 1", ovr_flag);
        end
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL ovr_latency: got %0d want 8", lat);
        end
        checks++;
        if (mix_out !== e.mix) begin
            errors++;
            $display("FAIL ovr_mix: got %h want %h", mix_out, e.mix);
        end
        repeat (20) tick();
        checks++;
        if (vld_cnt - start !== 1 || ovr_flag !== 1'b1) begin
            errors++;
            $display("FAIL ovr_single_vld: got pulses=%0d ovr=%b want 1 pulse ovr=1", vld_cnt - start, ovr_flag);
        end
    endtask

    task automatic test_reset_midframe();
        int lat, start;
        exp_t e;
        fill(700, 800, 'h300, 'h900);
        drive_frame();
        start = vld_cnt;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_vld, mix_out} !== '0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b vld=%b mix=%h want 0", busy, out_vld, mix_out);
        end
        void'(exp_q.pop_front());
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (vld_cnt !== start || mix_out !== '0) begin
            errors++;
            $display("FAIL midreset_no_vld: got pulses=%0d mix=%h want 0 pulses mix=0", vld_cnt - start, mix_out);
        end
        fill(-250, 1300, 'h480, 'h800);
        smp[1][4] = -20000;
        drive_frame();
        wait_out(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 13 || mix_out !== e.mix) begin
            errors++;
            $display("FAIL midreset_recover: got lat=%0d mix=%h want lat=13 mix=%h", lat, mix_out, e.mix);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            for (int c = 0; c < NC; c++)
                for (int b = 0; b < NB; b++) smp[c][b] = int'($urandom_range(0, 16000)) - 8000;
            for (int b = 0; b < NB; b++) pot[b] = int'($urandom_range(0, 4095));
            if (n == 1) pot[2] = 0;
            vol_i = int'($urandom_range(0, 4095));
            drive_frame();
            wait_out(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== 13 || mix_out !== e.mix || sat_flag !== e.sat || ovr_flag !== 1'b0) begin
                errors++;
                $display("FAIL b2b_frame%0d: got lat=%0d mix=%h sat=%b ovr=%b want lat=13 mix=%h sat=%b ovr=0",
                         n, lat, mix_out, sat_flag, ovr_flag, e.mix, e.sat);
            end
        end
    endtask

    task automatic test_small_params();
        int lat;
        logic [63:0] m;
        bit s;
        smp[0][0] = 1000; smp[0][1] = -300; smp[0][2] = 50;
        pot[0] = 'h400; pot[1] = 'h200; pot[2] = 'h800;
        vol_i = 'h600;
        for (int b = 0; b < NB2; b++) begin
            s_bands[b*SW +: SW] = 16'(smp[0][b]);
            s_pots[b*PW +: PW] = 12'(pot[b]);
        end
        s_vol = 12'(vol_i);
        model(1, NB2, m, s);
        s_smpl_vld = 1'b1;
        tick();
        s_smpl_vld = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (s_vld !== 1'b1 && lat < 40);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL small_latency: got %0d want 5", lat);
        end
        checks++;
        if (s_mix !== m[15:0] || s_sat !== s) begin
            errors++;
            $display("FAIL small_mix: got %h sat=%b want %h sat=%b", s_mix, s_sat, m[15:0], s);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_floor();
        test_snapshot();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        test_small_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
